// File: rtl/risc8_cpu.sv
// risc8_cpu: 8-bit accumulator CPU with a unified 32x8 memory.
// The memory is filled serially through the load port while the core is held.
// The core then runs a two-cycle fetch/execute loop starting at address 0.
module risc8_cpu (
    input  logic       clock,
    input  logic       reset,
    input  logic       Load,
    input  logic [7:0] data_in,
    output logic [7:0] Instruction,
    output logic [7:0] Acc,
    output logic [7:0] Mem,
    output logic [4:0] Program_counter
);

    typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

    state_e     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [4:0] la_q, la_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] mem_q [32];

    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;

    logic [2:0] op;
    logic [4:0] addr;
    logic [7:0] operand;

    assign op      = ir_q[7:5];
    assign addr    = ir_q[4:0];
    assign operand = mem_q[addr];

    // Next-state and memory write decode for load mode and the fetch/execute loop.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        la_d      = la_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        mem_we    = 1'b0;
        mem_waddr = la_q;
        mem_wdata = data_in;
        if (Load) begin
            // Core held; PC rewinds so execution restarts at 0 once Load drops.
            mem_we    = 1'b1;
            mem_waddr = la_q;
            mem_wdata = data_in;
            la_d      = la_q + 5'd1;
            pc_d      = 5'd0;
            state_d   = StFetch;
        end else begin
            case (state_q)
                StFetch: begin
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_q + 5'd1;
                    state_d = StExec;
                end
                StExec: begin
                    state_d = StFetch;
                    case (op)
                        3'b000: state_d = StHalt;
                        3'b001: if (acc_q == 8'd0) pc_d = pc_q + 5'd1;
                        3'b010: acc_d = acc_q + operand;
                        3'b011: acc_d = acc_q & operand;
                        3'b100: acc_d = acc_q ^ operand;
                        3'b101: acc_d = operand;
                        3'b110: begin
                            mem_we    = 1'b1;
                            mem_waddr = addr;
                            mem_wdata = acc_q;
                        end
                        3'b111: pc_d = addr;
                    endcase
                end
                StHalt: ;
                default: state_d = StFetch;
            endcase
        end
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= 5'd0;
            la_q    <= 5'd0;
            acc_q   <= 8'd0;
            ir_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            la_q    <= la_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
        end
    end

    // Memory write port; contents survive reset but reset still blocks any write.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign Instruction     = ir_q;
    assign Acc             = acc_q;
    assign Mem             = operand;
    assign Program_counter = pc_q;

endmodule

// File: tb/tb_risc8_cpu.sv
// Testbench for risc8_cpu: instruction-level reference model, random and directed programs.
module tb_risc8_cpu;

    logic       clock;
    logic       reset;
    logic       Load;
    logic [7:0] data_in;
    logic [7:0] Instruction;
    logic [7:0] Acc;
    logic [7:0] Mem;
    logic [4:0] Program_counter;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state advanced one whole instruction at a time.
    logic [7:0] m_mem [32];
    logic [4:0] m_pc;
    logic [4:0] m_la;
    logic [7:0] m_acc;
    logic [7:0] m_ir;
    bit         m_halt;

    risc8_cpu dut (
        .clock          (clock),
        .reset          (reset),
        .Load           (Load),
        .data_in        (data_in),
        .Instruction    (Instruction),
        .Acc            (Acc),
        .Mem            (Mem),
        .Program_counter(Program_counter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Load  = 1'b0;
        tick();
        reset  = 1'b0;
        m_pc   = 5'd0;
        m_acc  = 8'd0;
        m_ir   = 8'd0;
        m_la   = 5'd0;
        m_halt = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] w);
        Load    = 1'b1;
        data_in = w;
        tick();
        Load         = 1'b0;
        m_mem[m_la]  = w;
        m_la         = m_la + 5'd1;
        m_pc         = 5'd0;
        m_halt       = 1'b0;
    endtask

    // Two clocks in run mode == one instruction in the model.
    task automatic run_instr();
        logic [4:0] a;
        Load = 1'b0;
        tick();
        tick();
        if (!m_halt) begin
            m_ir = m_mem[m_pc];
            m_pc = m_pc + 5'd1;
            a    = m_ir[4:0];
            case (m_ir[7:5])
                3'd0: m_halt = 1'b1;
                3'd1: if (m_acc == 8'd0) m_pc = m_pc + 5'd1;
                3'd2: m_acc = m_acc + m_mem[a];
                3'd3: m_acc = m_acc & m_mem[a];
                3'd4: m_acc = m_acc ^ m_mem[a];
                3'd5: m_acc = m_mem[a];
                3'd6: m_mem[a] = m_acc;
                3'd7: m_pc = a;
            endcase
        end
    endtask

    task automatic test_reset();
        Load    = 1'b1;
        data_in = 8'h5A;
        reset   = 1'b1;
        tick();
        do_reset();
        checks++;
        if ({Program_counter, Acc, Instruction} !== 21'd0) begin
            errors++;
            $display("FAIL reset: got pc=%h acc=%h ir=%h want 00/00/00",
                     Program_counter, Acc, Instruction);
        end
    endtask

    task automatic test_load();
        do_reset();
        for (int i = 0; i < 32; i++) load_word(8'($urandom_range(0, 255)));
        checks++;
        if ({Program_counter, Acc, Instruction} !== 21'd0) begin
            errors++;
            $display("FAIL load_hold: got pc=%h acc=%h ir=%h want 00/00/00",
                     Program_counter, Acc, Instruction);
        end
        // Read every word back by placing JMP k at address 0 and fetching it.
        // k=1 runs without reset, so its word lands at 0 only if LA wrapped.
        for (int k = 1; k < 32; k++) begin
            logic [7:0] exp_ir;
            logic [7:0] exp_mem;
            if (k != 1) do_reset();
            load_word({3'b111, 5'(k)});
            Load = 1'b0;
            tick();
            exp_ir  = m_mem[0];
            exp_mem = m_mem[k];
            checks++;
            if ({Program_counter, Instruction, Mem} !== {5'd1, exp_ir, exp_mem}) begin
                errors++;
                $display("FAIL readback k=%0d: got pc=%h ir=%h mem=%h want pc=01 ir=%h mem=%h",
                         k, Program_counter, Instruction, Mem, exp_ir, exp_mem);
            end
        end
    endtask

    task automatic test_random_programs();
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int i = 0; i < 32; i++) begin
                logic [2:0] op;
                op = ($urandom_range(0, 31) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                load_word({op, 5'($urandom_range(0, 31))});
            end
            for (int s = 0; s < 40; s++) begin
                run_instr();
                checks++;
                if ({Program_counter, Acc, Instruction, Mem} !==
                    {m_pc, m_acc, m_ir, m_mem[m_ir[4:0]]}) begin
                    errors++;
                    $display("FAIL rand p%0d s%0d: got pc=%h acc=%h ir=%h mem=%h want pc=%h acc=%h ir=%h mem=%h",
                             p, s, Program_counter, Acc, Instruction, Mem,
                             m_pc, m_acc, m_ir, m_mem[m_ir[4:0]]);
                end
            end
        end
    endtask

    task automatic test_program();
        logic [7:0] prog [32];
        logic [4:0] ep [15] = '{5'h1E, 5'h03, 5'h04, 5'h06, 5'h07, 5'h08, 5'h0A, 5'h0B,
                                5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11, 5'h12};
        logic [7:0] ea [15] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                8'hFF, 8'h00, 8'hF0, 8'h10, 8'hF0, 8'h30, 8'h30};
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
        prog[5'h00] = 8'hFE;  // JMP 1E
        prog[5'h1E] = 8'hE3;  // JMP 03
        prog[5'h03] = 8'hBA;  // LDA 1A
        prog[5'h04] = 8'h20;  // SKZ
        prog[5'h06] = 8'hBB;  // LDA 1B
        prog[5'h07] = 8'h20;  // SKZ
        prog[5'h08] = 8'hEA;  // JMP 0A
        prog[5'h0A] = 8'hDC;  // STO 1C
        prog[5'h0B] = 8'hBC;  // LDA 1C
        prog[5'h0C] = 8'h9B;  // XOR 1B
        prog[5'h0D] = 8'hB4;  // LDA 14
        prog[5'h0E] = 8'h55;  // ADD 15
        prog[5'h0F] = 8'hB4;  // LDA 14
        prog[5'h10] = 8'h76;  // AND 16
        prog[5'h11] = 8'h00;  // HLT
        prog[5'h14] = 8'hF0;
        prog[5'h15] = 8'h20;
        prog[5'h16] = 8'h3C;
        prog[5'h1A] = 8'h00;
        prog[5'h1B] = 8'hFF;
        do_reset();
        for (int i = 0; i < 32; i++) load_word(prog[i]);
        for (int s = 0; s < 15; s++) begin
            run_instr();
            checks++;
            if ({Program_counter, Acc} !== {ep[s], ea[s]}) begin
                errors++;
                $display("FAIL prog s%0d: got pc=%h acc=%h want pc=%h acc=%h",
                         s, Program_counter, Acc, ep[s], ea[s]);
            end
            checks++;
            if ({Instruction, Mem} !== {m_ir, m_mem[m_ir[4:0]]}) begin
                errors++;
                $display("FAIL prog_ir s%0d: got ir=%h mem=%h want ir=%h mem=%h",
                         s, Instruction, Mem, m_ir, m_mem[m_ir[4:0]]);
            end
            if (s == 8) begin
                checks++;
                if (Mem !== 8'hFF) begin
                    errors++;
                    $display("FAIL sto_mem: got mem=%h want ff", Mem);
                end
            end
        end
    endtask

    task automatic test_halt();
        // Continues from the halted directed program.
        for (int c = 0; c < 24; c++) begin
            Load = 1'b0;
            tick();
            checks++;
            if ({Program_counter, Acc, Instruction} !== {5'h12, 8'h30, 8'h00}) begin
                errors++;
                $display("FAIL halt_freeze c%0d: got pc=%h acc=%h ir=%h want 12/30/00",
                         c, Program_counter, Acc, Instruction);
            end
        end
        // Load leaves HALT; LA wrapped to 0, so this word replaces address 0.
        load_word(8'hBB);
        checks++;
        if ({Program_counter, Acc, Instruction} !== {5'h00, 8'h30, 8'h00}) begin
            errors++;
            $display("FAIL halt_load: got pc=%h acc=%h ir=%h want 00/30/00",
                     Program_counter, Acc, Instruction);
        end
        run_instr();
        checks++;
        if ({Program_counter, Acc, Instruction} !== {m_pc, m_acc, m_ir} || Acc !== 8'hFF) begin
            errors++;
            $display("FAIL halt_resume: got pc=%h acc=%h ir=%h want pc=%h acc=%h ir=%h",
                     Program_counter, Acc, Instruction, m_pc, m_acc, m_ir);
        end
        run_instr();
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if ({Program_counter, Instruction} !== {5'h02, 8'h00}) begin
            errors++;
            $display("FAIL halt_again: got pc=%h ir=%h want 02/00", Program_counter, Instruction);
        end
        do_reset();
        checks++;
        if ({Program_counter, Acc, Instruction} !== 21'd0) begin
            errors++;
            $display("FAIL halt_reset: got pc=%h acc=%h ir=%h want 00/00/00",
                     Program_counter, Acc, Instruction);
        end
        run_instr();
        checks++;
        if ({Program_counter, Acc, Instruction} !== {5'h01, 8'hFF, 8'hBB}) begin
            errors++;
            $display("FAIL reset_restart: got pc=%h acc=%h ir=%h want 01/ff/bb",
                     Program_counter, Acc, Instruction);
        end
    endtask

    initial begin
        reset   = 1'b0;
        Load    = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_load();
        test_random_programs();
        test_program();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
